// File: rtl/axi_lite_sram_bridge.sv
// ----------------------------------------------------------------------------
// axi_lite_sram_bridge
//
// AXI4-Lite slave that turns single AW/W/AR requests into accesses on a
// single-port synchronous SRAM with one cycle of read latency. Only one
// transaction is in flight at a time. Writes take priority over reads.
// Addresses outside the SRAM window get SLVERR and never reach the SRAM.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   s_axi_aw*           write address channel (awprot ignored)
//   s_axi_w*            write data channel
//   s_axi_b*            write response channel (OKAY / SLVERR)
//   s_axi_ar*           read address channel (arprot ignored)
//   s_axi_r*            read data channel, rdata registered
//   sram_en             one-cycle access strobe
//   sram_we             byte write enables, 0 on reads
//   sram_addr           word address relative to BASE_ADDR
//   sram_wdata          write data
//   sram_rdata          read data, valid the cycle after a read strobe
//
// State table
//   IDLE     | accept AW/W (independently) or AR
//   WR_ISSUE | drive the SRAM write (if in range), latch bresp
//   WR_RESP  | bvalid high until bready
//   RD_ISSUE | drive the SRAM read strobe (if in range)
//   RD_CAPT  | capture sram_rdata (or 0) and rresp
//   RD_RESP  | rvalid high until rready
// ----------------------------------------------------------------------------
module axi_lite_sram_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MEM_WORDS = 1024
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [31:0]                  s_axi_awaddr,
    input  logic [2:0]                   s_axi_awprot,

    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    input  logic [31:0]                  s_axi_wdata,
    input  logic [3:0]                   s_axi_wstrb,

    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    output logic [1:0]                   s_axi_bresp,

    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    input  logic [31:0]                  s_axi_araddr,
    input  logic [2:0]                   s_axi_arprot,

    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [31:0]                  s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,

    output logic                         sram_en,
    output logic [3:0]                   sram_we,
    output logic [$clog2(MEM_WORDS)-1:0] sram_addr,
    output logic [31:0]                  sram_wdata,
    input  logic [31:0]                  sram_rdata
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [32:0] WIN_BYTES = 33'(MEM_WORDS) * 33'd4;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WR_ISSUE = 3'd1;
    localparam logic [2:0] WR_RESP  = 3'd2;
    localparam logic [2:0] RD_ISSUE = 3'd3;
    localparam logic [2:0] RD_CAPT  = 3'd4;
    localparam logic [2:0] RD_RESP  = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]  state;
    logic        aw_held;
    logic        w_held;
    logic [29:0] addr_q;     // word address of the active transaction (AW or AR)
    logic        hit_q;      // addr_q falls inside the SRAM window
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        aw_next;
    logic        w_next;
    logic [31:0] addr_off;

    // Byte address with addr[1:0] dropped, compared against the window.
    // The lower-bound test keeps addresses below BASE_ADDR from wrapping in.
    function automatic logic in_window(input logic [29:0] word);
        logic [31:0] byte_addr;
        logic [31:0] offset;
        byte_addr = {word, 2'b00};
        offset    = byte_addr - BASE_ADDR;
        return (byte_addr >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);
    endfunction

    // Readies are pure decodes of state/hold flags; arready additionally
    // backs off whenever any write activity is visible so writes win.
    assign s_axi_awready = (state == IDLE) && !aw_held && !rst;
    assign s_axi_wready  = (state == IDLE) && !w_held && !rst;
    assign s_axi_arready = (state == IDLE) && !aw_held && !w_held &&
                           !s_axi_awvalid && !s_axi_wvalid && !rst;

    assign aw_hs   = s_axi_awvalid && s_axi_awready;
    assign w_hs    = s_axi_wvalid && s_axi_wready;
    assign ar_hs   = s_axi_arvalid && s_axi_arready;
    assign aw_next = aw_held || aw_hs;
    assign w_next  = w_held || w_hs;

    assign addr_off   = {addr_q, 2'b00} - BASE_ADDR;
    assign sram_addr  = addr_off[AW+1:2];
    assign sram_wdata = wdata_q;

    // Strobes are gated by rst so nothing reaches the SRAM once reset is seen.
    always_comb begin
        sram_en = 1'b0;
        sram_we = 4'b0000;
        if (!rst && hit_q) begin
            if (state == WR_ISSUE) begin
                sram_en = 1'b1;
                sram_we = wstrb_q;
            end else if (state == RD_ISSUE) begin
                sram_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            addr_q       <= '0;
            hit_q        <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            s_axi_rvalid <= 1'b0;
            s_axi_rresp  <= RESP_OKAY;
            s_axi_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        aw_held <= 1'b1;
                        addr_q  <= s_axi_awaddr[31:2];
                        hit_q   <= in_window(s_axi_awaddr[31:2]);
                    end
                    if (w_hs) begin
                        w_held  <= 1'b1;
                        wdata_q <= s_axi_wdata;
                        wstrb_q <= s_axi_wstrb;
                    end
                    if (aw_next && w_next) begin
                        state <= WR_ISSUE;
                    end else if (ar_hs) begin
                        addr_q <= s_axi_araddr[31:2];
                        hit_q  <= in_window(s_axi_araddr[31:2]);
                        state  <= RD_ISSUE;
                    end
                end
                WR_ISSUE: begin
                    s_axi_bresp  <= hit_q ? RESP_OKAY : RESP_SLVERR;
                    s_axi_bvalid <= 1'b1;
                    state        <= WR_RESP;
                end
                WR_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        aw_held      <= 1'b0;
                        w_held       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                RD_ISSUE: begin
                    state <= RD_CAPT;
                end
                RD_CAPT: begin
                    s_axi_rdata  <= hit_q ? sram_rdata : 32'h0;
                    s_axi_rresp  <= hit_q ? RESP_OKAY : RESP_SLVERR;
                    s_axi_rvalid <= 1'b1;
                    state        <= RD_RESP;
                end
                RD_RESP: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Protection bits, sub-word address bits and the offset bits above the
    // SRAM range carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0],
                           s_axi_araddr[1:0], addr_off[31:AW+2], addr_off[1:0]};

endmodule

// File: tb/tb_axi_lite_sram_bridge.sv
// ----------------------------------------------------------------------------
// tb_axi_lite_sram_bridge
//
// Directed bench for axi_lite_sram_bridge with a behavioural 1024 x 32 SRAM
// (byte enables, one cycle read latency). Inputs change 1 ns after posedge,
// outputs are sampled on negedge.
// ----------------------------------------------------------------------------
module tb_axi_lite_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    axi_lite_sram_bridge #(
        .BASE_ADDR(32'h0000_0000),
        .MEM_WORDS(1024)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_awaddr (s_axi_awaddr),
        .s_axi_awprot (s_axi_awprot),
        .s_axi_wvalid (s_axi_wvalid),
        .s_axi_wready (s_axi_wready),
        .s_axi_wdata  (s_axi_wdata),
        .s_axi_wstrb  (s_axi_wstrb),
        .s_axi_bvalid (s_axi_bvalid),
        .s_axi_bready (s_axi_bready),
        .s_axi_bresp  (s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arprot (s_axi_arprot),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    // Behavioural SRAM: read-before-write, data valid the cycle after sram_en.
    logic [31:0] mem [0:1023];
    always_ff @(posedge clk) begin
        if (sram_en) begin
            if (sram_we[0]) mem[sram_addr][7:0]   <= sram_wdata[7:0];
            if (sram_we[1]) mem[sram_addr][15:8]  <= sram_wdata[15:8];
            if (sram_we[2]) mem[sram_addr][23:16] <= sram_wdata[23:16];
            if (sram_we[3]) mem[sram_addr][31:24] <= sram_wdata[31:24];
            sram_rdata <= mem[sram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full write with AW and W in the same cycle and bready held high.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic en_seen,
                            output logic [3:0] we_seen, output logic [9:0] addr_seen);
        logic done;
        done = 1'b0; en_seen = 1'b0; we_seen = 4'h0; addr_seen = '0; resp = 2'b11;
        tick();
        s_axi_awvalid = 1'b1; s_axi_awaddr = a;
        s_axi_wvalid  = 1'b1; s_axi_wdata  = d; s_axi_wstrb = s;
        s_axi_bready  = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        for (int n = 0; n < 10 && !done; n++) begin
            @(negedge clk);
            if (sram_en) begin
                en_seen = 1'b1; we_seen = sram_we; addr_seen = sram_addr;
            end
            if (s_axi_bvalid) begin
                resp = s_axi_bresp; done = 1'b1;
            end
            tick();
        end
        s_axi_bready = 1'b0;
        chk("wr_done", {31'd0, done}, 32'd1);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                           output logic [1:0] resp, output logic en_seen);
        logic acc;
        logic done;
        acc = 1'b0; done = 1'b0; en_seen = 1'b0; data = 32'hxxxx_xxxx; resp = 2'b11;
        tick();
        s_axi_arvalid = 1'b1; s_axi_araddr = a; s_axi_rready = 1'b1;
        for (int n = 0; n < 10 && !acc; n++) begin
            @(negedge clk);
            if (s_axi_arready) acc = 1'b1;
            tick();
        end
        s_axi_arvalid = 1'b0;
        for (int n = 0; n < 10 && !done; n++) begin
            @(negedge clk);
            if (sram_en && sram_we == 4'h0) en_seen = 1'b1;
            if (s_axi_rvalid) begin
                data = s_axi_rdata; resp = s_axi_rresp; done = 1'b1;
            end
            tick();
        end
        s_axi_rready = 1'b0;
        chk("rd_done", {31'd0, done}, 32'd1);
    endtask

    logic [1:0]  resp;
    logic        en;
    logic [3:0]  we;
    logic [9:0]  sa;
    logic [31:0] rd;
    logic        seen_en;
    logic        seen_b;
    logic        seen_r;

    initial begin
        rst = 1'b1;
        s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awprot = 3'b000;
        s_axi_wvalid  = 1'b0; s_axi_wdata  = '0; s_axi_wstrb  = 4'h0;
        s_axi_bready  = 1'b0;
        s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arprot = 3'b000;
        s_axi_rready  = 1'b0;

        // Reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_awready", {31'd0, s_axi_awready}, 32'd0);
        chk("rst_wready",  {31'd0, s_axi_wready},  32'd0);
        chk("rst_arready", {31'd0, s_axi_arready}, 32'd0);
        chk("rst_bvalid",  {31'd0, s_axi_bvalid},  32'd0);
        chk("rst_rvalid",  {31'd0, s_axi_rvalid},  32'd0);
        chk("rst_sram_en", {31'd0, sram_en},       32'd0);
        chk("rst_sram_we", {28'd0, sram_we},       32'd0);
        chk("rst_rdata",   s_axi_rdata,            32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_awready", {31'd0, s_axi_awready}, 32'd1);
        chk("idle_wready",  {31'd0, s_axi_wready},  32'd1);
        chk("idle_arready", {31'd0, s_axi_arready}, 32'd1);
        chk("idle_bresp",   {30'd0, s_axi_bresp},   32'd0);
        chk("idle_rresp",   {30'd0, s_axi_rresp},   32'd0);

        // Write 0x10 = DEADBEEF, AW and W in the same cycle T
        tick();
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h10;
        s_axi_wvalid  = 1'b1; s_axi_wdata  = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF;
        @(negedge clk);
        chk("w1_T_sram_en", {31'd0, sram_en}, 32'd0);
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(negedge clk);
        chk("w1_T1_sram_en",    {31'd0, sram_en},       32'd1);
        chk("w1_T1_sram_we",    {28'd0, sram_we},       32'hF);
        chk("w1_T1_sram_addr",  {22'd0, sram_addr},     32'd4);
        chk("w1_T1_sram_wdata", sram_wdata,             32'hDEAD_BEEF);
        chk("w1_T1_awready",    {31'd0, s_axi_awready}, 32'd0);
        chk("w1_T1_bvalid",     {31'd0, s_axi_bvalid},  32'd0);
        tick();
        @(negedge clk);
        chk("w1_T2_bvalid",  {31'd0, s_axi_bvalid}, 32'd1);
        chk("w1_T2_bresp",   {30'd0, s_axi_bresp},  32'd0);
        chk("w1_T2_sram_en", {31'd0, sram_en},      32'd0);
        tick();
        s_axi_bready = 1'b1;
        @(negedge clk);
        chk("w1_T3_bvalid_hold", {31'd0, s_axi_bvalid}, 32'd1);
        tick();
        s_axi_bready = 1'b0;
        @(negedge clk);
        chk("w1_done_bvalid",  {31'd0, s_axi_bvalid},  32'd0);
        chk("w1_done_awready", {31'd0, s_axi_awready}, 32'd1);

        // W at T, AW at T+3: write 0x20 = 12345678
        tick();
        s_axi_wvalid = 1'b1; s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'hF;
        @(negedge clk);
        chk("w2_T_wready", {31'd0, s_axi_wready}, 32'd1);
        tick();
        s_axi_wvalid = 1'b0;
        @(negedge clk);
        chk("w2_T1_wready",  {31'd0, s_axi_wready},  32'd0);
        chk("w2_T1_arready", {31'd0, s_axi_arready}, 32'd0);
        chk("w2_T1_sram_en", {31'd0, sram_en},       32'd0);
        tick();
        @(negedge clk);
        chk("w2_T2_wready", {31'd0, s_axi_wready}, 32'd0);
        tick();
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h20;
        @(negedge clk);
        chk("w2_T3_wready",  {31'd0, s_axi_wready},  32'd0);
        chk("w2_T3_awready", {31'd0, s_axi_awready}, 32'd1);
        chk("w2_T3_sram_en", {31'd0, sram_en},       32'd0);
        tick();
        s_axi_awvalid = 1'b0;
        @(negedge clk);
        chk("w2_T4_sram_en",   {31'd0, sram_en},   32'd1);
        chk("w2_T4_sram_we",   {28'd0, sram_we},   32'hF);
        chk("w2_T4_sram_addr", {22'd0, sram_addr}, 32'd8);
        chk("w2_T4_bvalid",    {31'd0, s_axi_bvalid}, 32'd0);
        tick();
        s_axi_bready = 1'b1;
        @(negedge clk);
        chk("w2_T5_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
        chk("w2_T5_bresp",  {30'd0, s_axi_bresp},  32'd0);
        tick();
        s_axi_bready = 1'b0;
        @(negedge clk);
        chk("w2_done_bvalid", {31'd0, s_axi_bvalid}, 32'd0);

        // Read 0x10 with rready held low for 5 cycles of rvalid
        tick();
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h10;
        @(negedge clk);
        chk("r1_T_arready", {31'd0, s_axi_arready}, 32'd1);
        tick();
        s_axi_arvalid = 1'b0;
        @(negedge clk);
        chk("r1_T1_sram_en",   {31'd0, sram_en},   32'd1);
        chk("r1_T1_sram_we",   {28'd0, sram_we},   32'd0);
        chk("r1_T1_sram_addr", {22'd0, sram_addr}, 32'd4);
        chk("r1_T1_rvalid",    {31'd0, s_axi_rvalid}, 32'd0);
        tick();
        @(negedge clk);
        chk("r1_T2_rvalid", {31'd0, s_axi_rvalid}, 32'd0);
        tick();
        @(negedge clk);
        chk("r1_T3_rvalid", {31'd0, s_axi_rvalid}, 32'd1);
        chk("r1_T3_rdata",  s_axi_rdata,           32'hDEAD_BEEF);
        chk("r1_T3_rresp",  {30'd0, s_axi_rresp},  32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk("r1_hold_rvalid", {31'd0, s_axi_rvalid}, 32'd1);
            chk("r1_hold_rdata",  s_axi_rdata,           32'hDEAD_BEEF);
            chk("r1_hold_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
        end
        tick();
        s_axi_rready = 1'b1;
        @(negedge clk);
        chk("r1_hs_rvalid", {31'd0, s_axi_rvalid}, 32'd1);
        tick();
        s_axi_rready = 1'b0;
        @(negedge clk);
        chk("r1_done_rvalid", {31'd0, s_axi_rvalid}, 32'd0);

        // Partial write: byte 1 of word 1
        do_write(32'h4, 32'h1122_3344, 4'hF, resp, en, we, sa);
        chk("pw_full_bresp", {30'd0, resp}, 32'd0);
        do_write(32'h4, 32'h0000_AB00, 4'b0010, resp, en, we, sa);
        chk("pw_en",    {31'd0, en},   32'd1);
        chk("pw_we",    {28'd0, we},   32'b0010);
        chk("pw_addr",  {22'd0, sa},   32'd1);
        chk("pw_bresp", {30'd0, resp}, 32'd0);
        do_read(32'h4, rd, resp, en);
        chk("pw_rdata", rd,            32'h1122_AB44);
        chk("pw_rresp", {30'd0, resp}, 32'd0);

        // Window boundaries: last word in range, first word past the end
        do_write(32'hFFC, 32'hA5A5_0FF0, 4'hF, resp, en, we, sa);
        chk("last_wr_en",    {31'd0, en},   32'd1);
        chk("last_wr_addr",  {22'd0, sa},   32'h3FF);
        chk("last_wr_bresp", {30'd0, resp}, 32'd0);
        do_read(32'hFFC, rd, resp, en);
        chk("last_rd_rdata", rd,            32'hA5A5_0FF0);
        chk("last_rd_en",    {31'd0, en},   32'd1);
        do_write(32'h1000, 32'hFFFF_FFFF, 4'hF, resp, en, we, sa);
        chk("oor_wr_en",    {31'd0, en},   32'd0);
        chk("oor_wr_bresp", {30'd0, resp}, 32'b10);
        do_read(32'h1000, rd, resp, en);
        chk("oor_rd_en",    {31'd0, en},   32'd0);
        chk("oor_rd_rresp", {30'd0, resp}, 32'b10);
        chk("oor_rd_rdata", rd,            32'd0);
        do_read(32'h0, rd, resp, en);
        chk("oor_no_wrap_word0", rd, 32'h0000_0000 | mem[0]);

        // AW and AR in the same IDLE cycle: write first, then read
        tick();
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h30;
        s_axi_wvalid  = 1'b1; s_axi_wdata  = 32'h0BAD_F00D; s_axi_wstrb = 4'hF;
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h30;
        @(negedge clk);
        chk("col_T_arready", {31'd0, s_axi_arready}, 32'd0);
        chk("col_T_awready", {31'd0, s_axi_awready}, 32'd1);
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(negedge clk);
        chk("col_T1_sram_we", {28'd0, sram_we},       32'hF);
        chk("col_T1_arready", {31'd0, s_axi_arready}, 32'd0);
        tick();
        s_axi_bready = 1'b1;
        @(negedge clk);
        chk("col_T2_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
        chk("col_T2_rvalid", {31'd0, s_axi_rvalid}, 32'd0);
        tick();
        s_axi_bready = 1'b0;
        @(negedge clk);
        chk("col_idle_arready", {31'd0, s_axi_arready}, 32'd1);
        tick();
        s_axi_arvalid = 1'b0;
        @(negedge clk);
        chk("col_rd_sram_en",   {31'd0, sram_en},   32'd1);
        chk("col_rd_sram_addr", {22'd0, sram_addr}, 32'd12);
        tick();
        tick();
        s_axi_rready = 1'b1;
        @(negedge clk);
        chk("col_rd_rvalid", {31'd0, s_axi_rvalid}, 32'd1);
        chk("col_rd_rdata",  s_axi_rdata,           32'h0BAD_F00D);
        chk("col_rd_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
        tick();
        s_axi_rready = 1'b0;

        // Reset in the handshake cycle before WR_ISSUE discards the write
        do_write(32'h40, 32'h5555_AAAA, 4'hF, resp, en, we, sa);
        tick();
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h40;
        s_axi_wvalid  = 1'b1; s_axi_wdata  = 32'hCAFE_F00D; s_axi_wstrb = 4'hF;
        s_axi_bready  = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_awready", {31'd0, s_axi_awready}, 32'd0);
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        rst = 1'b0;
        seen_en = 1'b0; seen_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (sram_en) seen_en = 1'b1;
            if (s_axi_bvalid) seen_b = 1'b1;
            tick();
        end
        s_axi_bready = 1'b0;
        chk("rstw_no_sram_en", {31'd0, seen_en}, 32'd0);
        chk("rstw_no_bvalid",  {31'd0, seen_b},  32'd0);
        do_read(32'h40, rd, resp, en);
        chk("rstw_mem_kept", rd, 32'h5555_AAAA);

        // Reset during RD_CAPT discards the read response
        tick();
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h10; s_axi_rready = 1'b1;
        @(negedge clk);
        chk("rstr_arready", {31'd0, s_axi_arready}, 32'd1);
        tick();
        s_axi_arvalid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rstr_rvalid",  {31'd0, s_axi_rvalid},  32'd0);
        chk("rstr_rdata",   s_axi_rdata,            32'd0);
        chk("rstr_rresp",   {30'd0, s_axi_rresp},   32'd0);
        chk("rstr_sram_en", {31'd0, sram_en},       32'd0);
        chk("rstr_arready", {31'd0, s_axi_arready}, 32'd1);
        seen_r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            if (s_axi_rvalid) seen_r = 1'b1;
        end
        s_axi_rready = 1'b0;
        chk("rstr_no_rvalid", {31'd0, seen_r}, 32'd0);

        // Normal operation resumes after the aborted transactions
        do_read(32'h20, rd, resp, en);
        chk("post_rdata", rd,            32'h1234_5678);
        chk("post_rresp", {30'd0, resp}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
